mdio_master_ctrl: RTL and testbench

Parametrised MDIO management master for Clause 22 and Clause 45 frames. It generates MDC internally from clk_core with a programmable divider, so no separate 2.5 MHz clock is needed. Frames run under a start/busy/done handshake, and read data is captured. It sits between the register/CSR layer and the PHY management pins, with a tristate split (o_mdio, o_mdio_oe, i_mdio).

---
 rtl/mdio_master_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_mdio_master_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_master_ctrl.sv
// MDIO Clause 22 / Clause 45 management master with internal MDC divider.
// Optional MDIO_PREAMBLE_SUPPRESS_EN adds i_no_preamble to skip the preamble.
module mdio_master_ctrl #(
   parameter int unsigned CLK_DIV      = 20,
   parameter int unsigned PREAMBLE_LEN = 32
) (
   input  logic        clk_core,
   input  logic        aReset,
   input  logic        i_start,
   input  logic        i_cl45,
   input  logic [1:0]  i_op,
   input  logic [4:0]  i_phyaddr,
   input  logic [4:0]  i_regaddr,
   input  logic [15:0] i_data,
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
   input  logic        i_no_preamble,
`endif
   output logic        o_busy,
   output logic        o_done,
   output logic        o_err,
   output logic [15:0] o_data,
   output logic        o_mdc,
   output logic        o_mdio,
   output logic        o_mdio_oe,
   input  logic        i_mdio
);

   localparam int unsigned DIV_W   = $clog2(CLK_DIV);
   localparam int unsigned BIT_W   = 6;
   localparam int unsigned FRAME_W = 32;

   typedef enum logic [2:0] {
      ST_IDLE, ST_PREAMBLE, ST_HDR, ST_TA, ST_DATA, ST_DONE
   } state_t;

   state_t             state, state_nx;
   logic [DIV_W-1:0]   div_cnt, div_nx;
   logic [BIT_W-1:0]   bit_cnt, bit_nx;
   logic [FRAME_W-1:0] tx_sr, tx_nx;
   logic [15:0]        rx_sr, rx_nx;
   logic               is_read, is_read_nx;
   logic               err_flag, err_flag_nx;
   logic               busy_nx, done_nx, err_nx, mdc_nx, mdio_nx, oe_nx;
   logic [15:0]        data_nx;

   logic               op_valid, skip_pre, phase_end, bit_end, last_bit;
   logic [15:0]        rx_shift;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
   assign skip_pre = i_no_preamble;
`else
   assign skip_pre = 1'b0;
`endif

   // Clause 22 only knows write (01) and read (10); Clause 45 uses all four codes.
   assign op_valid  = i_cl45 | (i_op == 2'b01) | (i_op == 2'b10);
   assign phase_end = (div_cnt == DIV_W'(CLK_DIV - 1));
   assign bit_end   = phase_end & o_mdc;
   assign last_bit  = (bit_cnt == BIT_W'(1));
   assign rx_shift  = {rx_sr[14:0], i_mdio};

   // Next-state and next-output logic.
   always_comb begin
      state_nx    = state;
      div_nx      = div_cnt;
      bit_nx      = bit_cnt;
      tx_nx       = tx_sr;
      rx_nx       = rx_sr;
      is_read_nx  = is_read;
      err_flag_nx = err_flag;
      busy_nx     = o_busy;
      done_nx     = 1'b0;
      err_nx      = 1'b0;
      data_nx     = o_data;
      mdc_nx      = o_mdc;
      mdio_nx     = o_mdio;
      oe_nx       = o_mdio_oe;

      case (state)
         ST_IDLE: begin
            if (i_start) begin
               if (op_valid) begin
                  tx_nx       = {(i_cl45 ? 2'b00 : 2'b01), i_op, i_phyaddr, i_regaddr,
                                 2'b10, i_data};
                  is_read_nx  = i_op[1];
                  err_flag_nx = 1'b0;
                  div_nx      = DIV_W'(0);
                  busy_nx     = 1'b1;
                  mdc_nx      = 1'b0;
                  oe_nx       = 1'b1;
                  if (skip_pre) begin
                     state_nx = ST_HDR;
                     bit_nx   = BIT_W'(14);
                     mdio_nx  = tx_nx[FRAME_W-1];
                  end else begin
                     state_nx = ST_PREAMBLE;
                     bit_nx   = BIT_W'(PREAMBLE_LEN);
                     mdio_nx  = 1'b1;
                  end
               end else begin
                  done_nx = 1'b1;
                  err_nx  = 1'b1;
               end
            end
         end
         ST_PREAMBLE, ST_HDR, ST_TA, ST_DATA: begin
            div_nx = phase_end ? DIV_W'(0) : DIV_W'(div_cnt + 1'b1);
            if (phase_end) mdc_nx = ~o_mdc;
            if (bit_end) begin
               bit_nx = bit_cnt - BIT_W'(1);
               if (state != ST_PREAMBLE) begin
                  tx_nx   = {tx_sr[FRAME_W-2:0], 1'b0};
                  // Read frames release the line from the first TA bit onward.
                  mdio_nx = (is_read && !(state == ST_HDR && !last_bit)) ? 1'b1
                                                                         : tx_sr[FRAME_W-2];
               end
               if (state == ST_DATA) rx_nx = rx_shift;
               if (state == ST_TA && last_bit && is_read) err_flag_nx = err_flag | i_mdio;
               if (last_bit) begin
                  case (state)
                     ST_PREAMBLE: begin
                        state_nx = ST_HDR;
                        bit_nx   = BIT_W'(14);
                        mdio_nx  = tx_sr[FRAME_W-1];
                     end
                     ST_HDR: begin
                        state_nx = ST_TA;
                        bit_nx   = BIT_W'(2);
                        oe_nx    = ~is_read;
                     end
                     ST_TA: begin
                        state_nx = ST_DATA;
                        bit_nx   = BIT_W'(16);
                     end
                     ST_DATA: begin
                        state_nx = ST_DONE;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                        err_nx   = err_flag;
                        mdc_nx   = 1'b0;
                        mdio_nx  = 1'b1;
                        oe_nx    = 1'b0;
                        if (is_read) data_nx = rx_shift;
                     end
                     default: ;
                  endcase
               end
            end
         end
         ST_DONE:  state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk_core) begin
      if (aReset) begin
         state     <= ST_IDLE;
         div_cnt   <= '0;
         bit_cnt   <= '0;
         tx_sr     <= '0;
         rx_sr     <= '0;
         is_read   <= 1'b0;
         err_flag  <= 1'b0;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
         o_err     <= 1'b0;
         o_data    <= '0;
         o_mdc     <= 1'b0;
         o_mdio    <= 1'b1;
         o_mdio_oe <= 1'b0;
      end else begin
         state     <= state_nx;
         div_cnt   <= div_nx;
         bit_cnt   <= bit_nx;
         tx_sr     <= tx_nx;
         rx_sr     <= rx_nx;
         is_read   <= is_read_nx;
         err_flag  <= err_flag_nx;
         o_busy    <= busy_nx;
         o_done    <= done_nx;
         o_err     <= err_nx;
         o_data    <= data_nx;
         o_mdc     <= mdc_nx;
         o_mdio    <= mdio_nx;
         o_mdio_oe <= oe_nx;
      end
   end

endmodule

// File: tb/tb_mdio_master_ctrl.sv
// Scoreboard bench for mdio_master_ctrl (CLK_DIV=2, PREAMBLE_LEN=32).
// Build with MDIO_PREAMBLE_SUPPRESS_EN defined to also cover preamble suppression.
module tb_mdio_master_ctrl;

   logic        clk_core = 1'b0;
   logic        aReset   = 1'b1;
   logic        i_start  = 1'b0;
   logic        i_cl45   = 1'b0;
   logic [1:0]  i_op     = 2'b00;
   logic [4:0]  i_phyaddr = 5'd0;
   logic [4:0]  i_regaddr = 5'd0;
   logic [15:0] i_data   = 16'h0;
   logic        i_mdio;
   logic        o_busy, o_done, o_err, o_mdc, o_mdio, o_mdio_oe;
   logic [15:0] o_data;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
   logic        i_no_preamble = 1'b0;
`endif

   typedef struct {
      logic        err;
      logic [15:0] data;
      logic [63:0] tx;
      logic [63:0] oe;
      int          nbits;
      int          lat;
      int          t0;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          rise_cnt = 0;
   logic        mdc_q = 1'b0;
   logic [63:0] cap_tx = '0;
   logic [63:0] cap_oe = '0;
   logic [63:0] resp = '1;
   logic        chk_rst = 1'b0;

   mdio_master_ctrl #(.CLK_DIV(2), .PREAMBLE_LEN(32)) dut (
      .clk_core  (clk_core),
      .aReset    (aReset),
      .i_start   (i_start),
      .i_cl45    (i_cl45),
      .i_op      (i_op),
      .i_phyaddr (i_phyaddr),
      .i_regaddr (i_regaddr),
      .i_data    (i_data),
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
      .i_no_preamble (i_no_preamble),
`endif
      .o_busy    (o_busy),
      .o_done    (o_done),
      .o_err     (o_err),
      .o_data    (o_data),
      .o_mdc     (o_mdc),
      .o_mdio    (o_mdio),
      .o_mdio_oe (o_mdio_oe),
      .i_mdio    (i_mdio)
   );

   always #5 clk_core = ~clk_core;

   initial forever begin
      @(posedge clk_core);
      cyc++;
   end

   // PHY model: bit k of the frame (k-th MDC rise) drives resp[63-k]; idle line floats high.
   assign i_mdio = (rise_cnt == 0 || rise_cnt > 64) ? 1'b1 : resp[64 - rise_cnt];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, want);
      end
   endtask

   // Monitor: captures each MDC rise and scores every o_done against the queue.
   initial forever begin
      @(negedge clk_core);
      if (o_done) begin
         if (q.size() == 0) begin
            chk("unexpected_done", 64'(o_done), 64'(0));
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("err",       64'(o_err), 64'(e.err));
            chk("data",      64'(o_data), 64'(e.data));
            chk("latency",   64'(cyc - e.t0), 64'(e.lat));
            chk("mdc_rises", 64'(rise_cnt), 64'(e.nbits));
            chk("mdio_bits", cap_tx & e.oe, e.tx & e.oe);
            chk("mdio_oe",   cap_oe, e.oe);
         end
      end
      if (o_mdc && !mdc_q) begin
         rise_cnt++;
         cap_tx = {cap_tx[62:0], o_mdio};
         cap_oe = {cap_oe[62:0], o_mdio_oe};
      end
      mdc_q = o_mdc;
      if (!o_busy) begin
         rise_cnt = 0;
         cap_tx   = '0;
         cap_oe   = '0;
      end
      if (chk_rst) begin
         chk("rst_busy", 64'(o_busy), 64'(0));
         chk("rst_done", 64'(o_done), 64'(0));
         chk("rst_err",  64'(o_err), 64'(0));
         chk("rst_data", 64'(o_data), 64'(0));
         chk("rst_mdc",  64'(o_mdc), 64'(0));
         chk("rst_mdio", 64'(o_mdio), 64'(1));
         chk("rst_oe",   64'(o_mdio_oe), 64'(0));
      end
   end

   task automatic issue(input logic cl45, input logic [1:0] op, input logic [4:0] phy,
                        input logic [4:0] rg, input logic [15:0] d, input logic nop,
                        input logic valid, input logic push, input logic xerr,
                        input logic [15:0] xdata, input logic [63:0] xtx,
                        input logic [63:0] xoe);
      exp_t e;
      @(negedge clk_core);
      i_cl45    = cl45;
      i_op      = op;
      i_phyaddr = phy;
      i_regaddr = rg;
      i_data    = d;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
      i_no_preamble = nop;
`endif
      i_start   = 1'b1;
      e.err   = xerr;
      e.data  = xdata;
      e.tx    = xtx;
      e.oe    = xoe;
      e.nbits = valid ? (nop ? 32 : 64) : 0;
      e.lat   = 1 + e.nbits * 4;
      e.t0    = cyc;
      if (push) q.push_back(e);
      @(negedge clk_core);
      i_start   = 1'b0;
      i_data    = ~d;
      i_phyaddr = ~phy;
      i_regaddr = ~rg;
   endtask

   task automatic wait_q();
      for (int i = 0; i < 2000; i++) begin
         if (q.size() == 0) break;
         @(negedge clk_core);
      end
      if (q.size() != 0) begin
         $display("FAIL timeout: %0d responses still pending, expected 0", q.size());
         $fatal(1, "timeout");
      end
      repeat (3) @(negedge clk_core);
   endtask

   task automatic pulse_reset_check();
      @(posedge clk_core);
      #1 aReset = 1'b0;
      chk_rst = 1'b1;
      @(posedge clk_core);
      #1 chk_rst = 1'b0;
   endtask

   initial begin
      logic [63:0] ones;
      logic [63:0] rd_oe;
      ones  = '1;
      rd_oe = 64'hFFFF_FFFF_FFFC_0000;

      repeat (3) @(posedge clk_core);
      pulse_reset_check();

      // CL22 write, with a stray i_start while busy
      resp = '1;
      issue(1'b0, 2'b01, 5'd5, 5'h1F, 16'hBEEF, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000,
            {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd5, 5'h1F, 2'b10, 16'hBEEF}, ones);
      repeat (20) @(negedge clk_core);
      i_start = 1'b1;
      @(negedge clk_core);
      i_start = 1'b0;
      wait_q();

      // CL45 read (op 11), PHY answers 0x1234 with TA second bit 0
      resp = {32'hFFFF_FFFF, 14'h3FFF, 2'b10, 16'h1234};
      issue(1'b1, 2'b11, 5'd3, 5'd1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h1234,
            {32'hFFFF_FFFF, 2'b00, 2'b11, 5'd3, 5'd1, 18'h0}, rd_oe);
      wait_q();

      // CL22 read with no PHY present
      resp = '1;
      issue(1'b0, 2'b10, 5'd1, 5'd2, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFF,
            {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd1, 5'd2, 18'h0}, rd_oe);
      wait_q();

      // CL22 invalid ops 00 and 11
      issue(1'b0, 2'b00, 5'd4, 5'd4, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, '0, '0);
      wait_q();
      issue(1'b0, 2'b11, 5'd4, 5'd4, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, '0, '0);
      wait_q();

      // CL45 address frame leaves read data untouched
      issue(1'b1, 2'b00, 5'd7, 5'd3, 16'hABCD, 1'b0, 1'b1, 1'b1, 1'b0, 16'hFFFF,
            {32'hFFFF_FFFF, 2'b00, 2'b00, 5'd7, 5'd3, 2'b10, 16'hABCD}, ones);
      wait_q();

      // Reset during bit 40 of a write aborts it without o_done
      issue(1'b0, 2'b01, 5'd2, 5'd6, 16'h1357, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, '0, '0);
      repeat (160) @(negedge clk_core);
      aReset = 1'b1;
      pulse_reset_check();
      repeat (10) @(negedge clk_core);

      // Normal write after the abort
      issue(1'b0, 2'b01, 5'h1A, 5'd4, 16'h5A5A, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000,
            {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h1A, 5'd4, 2'b10, 16'h5A5A}, ones);
      wait_q();

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
      // CL45 address frame without preamble
      issue(1'b1, 2'b00, 5'd9, 5'd2, 16'hC0DE, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000,
            {32'h0, 2'b00, 2'b00, 5'd9, 5'd2, 2'b10, 16'hC0DE}, 64'h0000_0000_FFFF_FFFF);
      wait_q();
`endif

      repeat (5) @(negedge clk_core);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
